// File: rtl/ripple_count_capture_if.sv
// Snapshot handshake bundle for ripple_count_capture.
// The design drives valid/data; the consumer drives req/ready.
interface ripple_count_capture_if #(
    parameter int unsigned EXT_W = 12
) ();
    logic             snap_req;
    logic             snap_ready;
    logic             snap_valid;
    logic [EXT_W-1:0] snap_data;

    modport master (
        output snap_req,
        output snap_ready,
        input  snap_valid,
        input  snap_data
    );

    modport slave (
        input  snap_req,
        input  snap_ready,
        output snap_valid,
        output snap_data
    );
endinterface

// File: rtl/ripple_count_capture.sv
// Samples an asynchronous ripple counter, de-glitches it, extends it to EXT_W bits
// through wrap tracking, and offers a held snapshot over a valid/ready port.
module ripple_count_capture #(
    parameter int unsigned IN_W     = 4,
    parameter int unsigned EXT_W    = 12,
    parameter int unsigned STABLE_N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       cnt_in,
    input  logic                  match_en,
    input  logic [EXT_W-1:0]      match_val,
    ripple_count_capture_if.slave snap,
    output logic [EXT_W-1:0]      count,
    output logic                  match_pulse,
    output logic                  wrap_pulse,
    output logic                  err_jump
);

    localparam int unsigned UP_W   = EXT_W - IN_W;
    localparam int unsigned STAB_W = $clog2(STABLE_N + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N);

    typedef enum logic {StIdle, StHold} snap_st_e;

    logic [IN_W-1:0]   s1_q, s2_q, s2p_q;
    logic              v1_q, v2_q, vp_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [IN_W-1:0]   acc_q;
    logic [UP_W-1:0]   upper_q;
    logic              aligned_q;
    logic              chg_q;
    logic              same, accept, first, step;
    logic [IN_W-1:0]   delta;

    snap_st_e          state_q, state_d;
    logic [EXT_W-1:0]  data_q, data_d;

    // Valid bits keep reset-zeroed sync flops from being taken as a real sample.
    always_comb begin
        same   = vp_q && (s2_q == s2p_q);
        stab_d = '0;
        if (same) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
        end
        accept = v2_q && ((32'(stab_d) + 32'd1) >= STABLE_N);
        first  = accept && !aligned_q;
        step   = accept && aligned_q && (s2_q != acc_q);
        delta  = s2_q - acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s2p_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            vp_q        <= 1'b0;
            stab_q      <= '0;
            acc_q       <= '0;
            upper_q     <= '0;
            aligned_q   <= 1'b0;
            chg_q       <= 1'b0;
            wrap_pulse  <= 1'b0;
            err_jump    <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            s1_q       <= cnt_in;
            s2_q       <= s1_q;
            s2p_q      <= s2_q;
            v1_q       <= 1'b1;
            v2_q       <= v1_q;
            vp_q       <= v2_q;
            stab_q     <= stab_d;
            chg_q      <= step;
            wrap_pulse <= 1'b0;
            err_jump   <= 1'b0;
            if (first) begin
                acc_q     <= s2_q;
                aligned_q <= 1'b1;
            end else if (step) begin
                acc_q <= s2_q;
                if (s2_q < acc_q) begin
                    upper_q    <= upper_q + 1'b1;
                    wrap_pulse <= 1'b1;
                end
                if (delta != IN_W'(1)) begin
                    err_jump <= 1'b1;
                end
            end
            // Only a real count change arms a match; moving match_val never does.
            match_pulse <= match_en && chg_q && (count == match_val);
        end
    end

    assign count = {upper_q, acc_q};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (snap.snap_req) begin
                    data_d  = count;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (snap.snap_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign snap.snap_valid = (state_q == StHold);
    assign snap.snap_data  = data_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Randomised scoreboard bench for ripple_count_capture: stimulus pushes expected
// count events and snapshots, a negedge monitor pops and compares them.
module tb_ripple_count_capture;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cnt_in = '0;
    logic        match_en = 1'b0;
    logic [11:0] match_val = '0;
    logic [11:0] count;
    logic        match_pulse, wrap_pulse, err_jump;
    int          cyc = 0;

    ripple_count_capture_if #(.EXT_W(12)) sif ();

    ripple_count_capture #(.IN_W(4), .EXT_W(12), .STABLE_N(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .match_en    (match_en),
        .match_val   (match_val),
        .snap        (sif.slave),
        .count       (count),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .err_jump    (err_jump)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt;
        bit wrap;
        bit err;
        bit match;
        int cyc;
    } ev_t;

    ev_t evq[$];
    int  snapq[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: extended count as plain integers.
    int  m_acc = 0;
    int  m_up = 0;
    bit  m_aligned = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int m_count();
        return (m_up * 16 + m_acc) % 4096;
    endfunction

    task automatic present(input int v, input int hold);
        bit w, e;
        int nc;
        cnt_in = 4'(v);
        if (!m_aligned) begin
            m_aligned = 1;
            m_acc = v;
            if (v != 0) evq.push_back('{cnt: m_count(), wrap: 0, err: 0, match: 0, cyc: cyc});
        end else if (v != m_acc) begin
            w = (v < m_acc);
            e = (((v - m_acc + 16) % 16) != 1);
            if (w) m_up = (m_up + 1) % 256;
            m_acc = v;
            nc = m_count();
            evq.push_back('{cnt: nc, wrap: w, err: e,
                            match: (match_en && (nc == int'(match_val))), cyc: cyc});
        end
        tick(hold);
    endtask

    task automatic glitch(input int g);
        int v;
        v = int'(cnt_in);
        cnt_in = 4'(g);
        tick(1);
        cnt_in = 4'(v);
        tick(6);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        m_aligned = 0;
        m_acc = 0;
        m_up = 0;
    endtask

    // Monitor
    bit  prev_rst = 1'b1;
    bit  pend_match = 1'b0;
    bit  pred_valid = 1'b0;
    bit  prev_valid = 1'b0;
    int  last_count = 0;
    int  held = 0;

    always @(negedge clk) begin
        ev_t e;
        if (prev_rst) begin
            check("reset_count", int'(count), 0);
            check("reset_pulses", int'({match_pulse, wrap_pulse, err_jump}), 0);
            check("reset_snap_data", int'(sif.snap_data), 0);
            last_count = 0;
            pend_match = 0;
        end else begin
            check("match_pulse", int'(match_pulse), int'(pend_match));
            pend_match = 0;
            if (int'(count) != last_count || wrap_pulse || err_jump) begin
                if (evq.size() == 0) begin
                    check("unexpected_count_event", int'(count), last_count);
                end else begin
                    e = evq.pop_front();
                    check("count", int'(count), e.cnt);
                    check("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
                    check("err_jump", int'(err_jump), int'(e.err));
                    check("latency", cyc - e.cyc, LAT);
                    pend_match = e.match;
                end
                last_count = int'(count);
            end
        end
        check("snap_valid", int'(sif.snap_valid), int'(pred_valid));
        if (sif.snap_valid && !prev_valid) begin
            if (snapq.size() == 0) check("unexpected_snapshot", 1, 0);
            else held = snapq.pop_front();
        end
        if (sif.snap_valid) check("snap_data", int'(sif.snap_data), held);
        pred_valid = rst ? 1'b0 : (sif.snap_valid ? !sif.snap_ready : sif.snap_req);
        prev_valid = sif.snap_valid;
        prev_rst   = rst;
    end

    initial begin
        int r, v, g, hold;
        sif.snap_req   = 1'b0;
        sif.snap_ready = 1'b0;
        #1;
        do_reset(3);
        present(0, 8);

        // Walk the full nibble and wrap once.
        for (int i = 1; i <= 16; i++) present(i % 16, 6);

        // Match on 0x01A, then a skip, a glitch, and a match_val move onto count.
        match_en  = 1'b1;
        match_val = 12'h01A;
        for (int i = 1; i <= 11; i++) present(i, 6);
        present(13, 6);
        glitch(3);
        match_val = 12'(m_count());
        tick(8);

        // Random steps, jumps and glitches.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            v = (m_acc + 1) % 16;
            match_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) match_val = 12'((m_count() + 1) % 4096);
            else match_val = 12'($urandom_range(0, 4095));
            hold = $urandom_range(6, 9);
            if (r < 6) begin
                present(v, hold);
            end else if (r < 8) begin
                present($urandom_range(0, 15), hold);
            end else begin
                g = $urandom_range(0, 15);
                if (g == m_acc) g = (g + 5) % 16;
                glitch(g);
            end
        end

        // Snapshot held across count changes, repeated request ignored in hold.
        match_en = 1'b0;
        sif.snap_req = 1'b1;
        snapq.push_back(m_count());
        tick(1);
        sif.snap_req = 1'b0;
        present((m_acc + 1) % 16, 3);
        sif.snap_req = 1'b1;
        tick(1);
        sif.snap_req = 1'b0;
        present((m_acc + 1) % 16, 6);
        sif.snap_ready = 1'b1;
        tick(1);
        sif.snap_ready = 1'b0;
        tick(3);

        // Reset while holding a snapshot.
        present((m_acc + 3) % 16, 6);
        sif.snap_req = 1'b1;
        snapq.push_back(m_count());
        tick(1);
        sif.snap_req = 1'b0;
        tick(3);
        v = m_acc;
        do_reset(1);
        present(v, 8);
        present((v + 1) % 16, 8);

        tick(10);
        check("events_drained", evq.size(), 0);
        check("snapshots_drained", snapq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
